masked_pipe_ctrl: RTL and testbench



---
 rtl/masked_ctrl_pkg.sv | 12 +
 rtl/masked_pipe_ctrl_if.sv | 32 +++
 rtl/ctrl_valid_shreg.sv | 25 ++
 rtl/masked_pipe_ctrl.sv | 99 +++++++++
 tb/tb_masked_pipe_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/masked_ctrl_pkg.sv
// Shared types for the masked gadget pipeline sequencer.
package masked_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam state_e STATE_RST = IDLE;

endpackage

// File: rtl/masked_pipe_ctrl_if.sv
// Handshake bundle between scheduler, randomness source, downstream and the sequencer.
interface masked_pipe_ctrl_if #(
  parameter int unsigned LATENCY = 4
);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             rnd_valid;
  logic             rnd_ready;
  logic             pipe_en;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] inflight;

  // Controller side
  modport master (
    input  in_valid, in_last, rnd_valid, out_ready,
    output in_ready, rnd_ready, pipe_en, out_valid, out_last, busy, done, inflight
  );

  // Environment side
  modport slave (
    output in_valid, in_last, rnd_valid, out_ready,
    input  in_ready, rnd_ready, pipe_en, out_valid, out_last, busy, done, inflight
  );

endinterface

// File: rtl/ctrl_valid_shreg.sv
// Enable-gated valid/last token shift register shadowing the datapath stages.
module ctrl_valid_shreg #(
  parameter int unsigned LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_vld,
  input  logic               in_lst,
  output logic [LATENCY-1:0] vld,
  output logic [LATENCY-1:0] lst
);

  // Shift left so bit LATENCY-1 is the output stage; works for LATENCY=1 too
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
    end else if (en) begin
      vld <= (vld << 1) | LATENCY'(in_vld);
      lst <= (lst << 1) | LATENCY'(in_lst);
    end
  end

endmodule

// File: rtl/masked_pipe_ctrl.sv
// Global-enable sequencer for a fixed-latency masked gadget pipeline with
// randomness-gated advance, output back-pressure and batch drain tracking.
module masked_pipe_ctrl
  import masked_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  masked_pipe_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  state_e             state;
  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] lst;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               busy;
  logic               done;
  logic               slot_free;
  logic               in_ready_c;
  logic               in_xfer;
  logic               pipe_en_c;
  logic               out_xfer;

  // Advance only with fresh randomness, a free output slot and something to move
  always_comb begin
    slot_free  = !vld[LATENCY-1] || bus.out_ready;
    in_ready_c = bus.rnd_valid && slot_free && (state != DRAIN);
    in_xfer    = bus.in_valid && in_ready_c;
    pipe_en_c  = bus.rnd_valid && slot_free && ((|vld) || in_xfer);
    out_xfer   = vld[LATENCY-1] && bus.out_ready && pipe_en_c;
    cnt_nxt    = inflight + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

  ctrl_valid_shreg #(
    .LATENCY (LATENCY)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .en     (pipe_en_c),
    .in_vld (in_xfer),
    .in_lst (in_xfer && bus.in_last),
    .vld    (vld),
    .lst    (lst)
  );

  // Batch FSM with registered busy/done and in-flight count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STATE_RST;
      busy     <= 1'b0;
      done     <= 1'b0;
      inflight <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= cnt_nxt;
      case (state)
        IDLE: begin
          if (in_xfer) begin
            state <= bus.in_last ? DRAIN : RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (in_xfer && bus.in_last) begin
            state <= DRAIN;
          end else if (cnt_nxt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_xfer && lst[LATENCY-1]) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.pipe_en   = pipe_en_c;
  assign bus.rnd_ready = pipe_en_c;
  assign bus.out_valid = vld[LATENCY-1];
  assign bus.out_last  = vld[LATENCY-1] && lst[LATENCY-1];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.inflight  = inflight;

endmodule

// File: tb/tb_masked_pipe_ctrl.sv
// Directed self-checking bench for masked_pipe_ctrl at LATENCY=4.
module tb_masked_pipe_ctrl;

  localparam int unsigned LAT   = 4;
  localparam int unsigned CNT_W = $clog2(LAT + 1);

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  masked_pipe_ctrl_if #(.LATENCY(LAT)) bus ();

  masked_pipe_ctrl #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic r, input logic o);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.rnd_valid = r;
    bus.out_ready = o;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    #2;
    checks += 8;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset.in_ready got=%b exp=0", bus.in_ready); end
    if (bus.rnd_ready !== 1'b0) begin errors++; $display("FAIL reset.rnd_ready got=%b exp=0", bus.rnd_ready); end
    if (bus.pipe_en !== 1'b0) begin errors++; $display("FAIL reset.pipe_en got=%b exp=0", bus.pipe_en); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset.out_valid got=%b exp=0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset.out_last got=%b exp=0", bus.out_last); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset.busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset.done got=%b exp=0", bus.done); end
    if (bus.inflight !== CNT_W'(0)) begin errors++; $display("FAIL reset.inflight got=%0d exp=0", bus.inflight); end
    rst = 1'b0;
  endtask

  // One item accepted at k=0 emerges at k=4
  task automatic test_single();
    logic             e_ov, e_pe, e_busy;
    logic [CNT_W-1:0] e_inf;
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      drive(k == 0, 1'b0, 1'b1, 1'b1);
      #2;
      e_ov   = (k == 4);
      e_pe   = (k <= 4);
      e_busy = (k >= 1 && k <= 4);
      e_inf  = (k >= 1 && k <= 4) ? CNT_W'(1) : CNT_W'(0);
      checks += 5;
      if (bus.out_valid !== e_ov) begin errors++; $display("FAIL single.out_valid k=%0d got=%b exp=%b", k, bus.out_valid, e_ov); end
      if (bus.pipe_en !== e_pe) begin errors++; $display("FAIL single.pipe_en k=%0d got=%b exp=%b", k, bus.pipe_en, e_pe); end
      if (bus.busy !== e_busy) begin errors++; $display("FAIL single.busy k=%0d got=%b exp=%b", k, bus.busy, e_busy); end
      if (bus.inflight !== e_inf) begin errors++; $display("FAIL single.inflight k=%0d got=%0d exp=%0d", k, bus.inflight, e_inf); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL single.done k=%0d got=%b exp=0", k, bus.done); end
      tick();
    end
  endtask

  // Eight consecutive items, k=0..7
  task automatic test_back_to_back();
    logic             e_ov, e_pe;
    logic [CNT_W-1:0] e_inf;
    int               acc, outs;
    do_reset();
    for (int k = 0; k <= 13; k++) begin
      drive(k <= 7, 1'b0, 1'b1, 1'b1);
      #2;
      acc   = (k < 8) ? k : 8;
      outs  = (k <= 4) ? 0 : ((k - 4 > 8) ? 8 : k - 4);
      e_ov  = (k >= 4 && k <= 11);
      e_pe  = (k <= 11);
      e_inf = CNT_W'(acc - outs);
      checks += 3;
      if (bus.out_valid !== e_ov) begin errors++; $display("FAIL b2b.out_valid k=%0d got=%b exp=%b", k, bus.out_valid, e_ov); end
      if (bus.pipe_en !== e_pe) begin errors++; $display("FAIL b2b.pipe_en k=%0d got=%b exp=%b", k, bus.pipe_en, e_pe); end
      if (bus.inflight !== e_inf) begin errors++; $display("FAIL b2b.inflight k=%0d got=%0d exp=%0d", k, bus.inflight, e_inf); end
      tick();
    end
  endtask

  // Randomness missing at k=2,3 delays the item to k=6
  task automatic test_rnd_stall();
    logic e_ov, e_pe, e_ir;
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      drive(k == 0, 1'b0, !(k == 2 || k == 3), 1'b1);
      #2;
      e_ov = (k == 6);
      e_pe = (k <= 1) || (k >= 4 && k <= 6);
      e_ir = !(k == 2 || k == 3);
      checks += 4;
      if (bus.out_valid !== e_ov) begin errors++; $display("FAIL stall.out_valid k=%0d got=%b exp=%b", k, bus.out_valid, e_ov); end
      if (bus.pipe_en !== e_pe) begin errors++; $display("FAIL stall.pipe_en k=%0d got=%b exp=%b", k, bus.pipe_en, e_pe); end
      if (bus.rnd_ready !== e_pe) begin errors++; $display("FAIL stall.rnd_ready k=%0d got=%b exp=%b", k, bus.rnd_ready, e_pe); end
      if (bus.in_ready !== e_ir) begin errors++; $display("FAIL stall.in_ready k=%0d got=%b exp=%b", k, bus.in_ready, e_ir); end
      tick();
    end
  endtask

  // Full pipeline, out_ready low k=4..6, continuous input until k=10
  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k <= 15; k++) begin
      drive(k <= 10, 1'b0, 1'b1, !(k >= 4 && k <= 6));
      #2;
      if (k >= 4 && k <= 6) begin
        checks += 4;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp.hold_in_ready k=%0d got=%b exp=0", k, bus.in_ready); end
        if (bus.pipe_en !== 1'b0) begin errors++; $display("FAIL bp.hold_pipe_en k=%0d got=%b exp=0", k, bus.pipe_en); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp.hold_out_valid k=%0d got=%b exp=1", k, bus.out_valid); end
        if (bus.inflight !== CNT_W'(4)) begin errors++; $display("FAIL bp.hold_inflight k=%0d got=%0d exp=4", k, bus.inflight); end
      end
      if (k >= 7 && k <= 10) begin
        checks += 3;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp.flow_in_ready k=%0d got=%b exp=1", k, bus.in_ready); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp.flow_out_valid k=%0d got=%b exp=1", k, bus.out_valid); end
        if (bus.inflight !== CNT_W'(4)) begin errors++; $display("FAIL bp.flow_inflight k=%0d got=%0d exp=4", k, bus.inflight); end
      end
      if (k >= 11 && k <= 14) begin
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp.drain_out_valid k=%0d got=%b exp=1", k, bus.out_valid); end
        if (bus.inflight !== CNT_W'(15 - k)) begin errors++; $display("FAIL bp.drain_inflight k=%0d got=%0d exp=%0d", k, bus.inflight, 15 - k); end
      end
      if (k == 15) begin
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp.end_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.inflight !== CNT_W'(0)) begin errors++; $display("FAIL bp.end_inflight got=%0d exp=0", bus.inflight); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp.end_busy got=%b exp=0", bus.busy); end
      end
      if (k >= 4) begin
        checks += 1;
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL bp.out_last k=%0d got=%b exp=0", k, bus.out_last); end
      end
      tick();
    end
  endtask

  // Three items, third last; upstream keeps pushing while draining
  task automatic test_last();
    logic e_ir, e_ov, e_ol, e_done, e_busy;
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      drive(k <= 6, k == 2, 1'b1, 1'b1);
      #2;
      e_ir   = (k <= 2) || (k >= 7);
      e_ov   = (k >= 4 && k <= 6);
      e_ol   = (k == 6);
      e_done = (k == 7);
      e_busy = (k >= 1 && k <= 6);
      checks += 5;
      if (bus.in_ready !== e_ir) begin errors++; $display("FAIL last.in_ready k=%0d got=%b exp=%b", k, bus.in_ready, e_ir); end
      if (bus.out_valid !== e_ov) begin errors++; $display("FAIL last.out_valid k=%0d got=%b exp=%b", k, bus.out_valid, e_ov); end
      if (bus.out_last !== e_ol) begin errors++; $display("FAIL last.out_last k=%0d got=%b exp=%b", k, bus.out_last, e_ol); end
      if (bus.done !== e_done) begin errors++; $display("FAIL last.done k=%0d got=%b exp=%b", k, bus.done, e_done); end
      if (bus.busy !== e_busy) begin errors++; $display("FAIL last.busy k=%0d got=%b exp=%b", k, bus.busy, e_busy); end
      tick();
    end
  endtask

  // Asynchronous reset with three items in flight
  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k <= 3; k++) begin
      drive(k <= 2, 1'b0, 1'b1, 1'b1);
      #2;
      if (k == 3) begin
        checks += 1;
        if (bus.inflight !== CNT_W'(3)) begin errors++; $display("FAIL arst.pre_inflight got=%0d exp=3", bus.inflight); end
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst.out_valid got=%b exp=0", bus.out_valid); end
        if (bus.inflight !== CNT_W'(0)) begin errors++; $display("FAIL arst.inflight got=%0d exp=0", bus.inflight); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst.busy got=%b exp=0", bus.busy); end
      end else begin
        tick();
      end
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      #2;
      checks += 2;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst.stale_out_valid k=%0d got=%b exp=0", k, bus.out_valid); end
      if (bus.pipe_en !== 1'b0) begin errors++; $display("FAIL arst.stale_pipe_en k=%0d got=%b exp=0", k, bus.pipe_en); end
      tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_back_to_back();
    test_rnd_stall();
    test_backpressure();
    test_last();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
